// File: rtl/wb_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wb_arb                                                          |
// | Purpose  : Multi-channel write-back arbiter, per-channel FIFOs drained by  |
// |            a round-robin grant into one registered GPR and CSR write port. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module wb_arb #(
  parameter int NCH   = 3,
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int RAW   = 5,
  parameter int CAW   = 12,
  parameter int CDW   = 32,
  localparam int c_chw = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NCH-1:0]      ch_valid_i,
  output logic [NCH-1:0]      ch_ready_o,
  input  logic [NCH-1:0]      ch_regs_wen_i,
  input  logic [NCH*RAW-1:0]  ch_rd_addr_i,
  input  logic [NCH*XLEN-1:0] ch_rd_data_i,
  input  logic [NCH-1:0]      ch_csr_wen_i,
  input  logic [NCH*CAW-1:0]  ch_csr_addr_i,
  input  logic [NCH*CDW-1:0]  ch_csr_data_i,
  output logic                regs_wen_o,
  output logic [RAW-1:0]      rd_addr_o,
  output logic [XLEN-1:0]     rd_data_o,
  output logic                csr_wen_o,
  output logic [CAW-1:0]      csr_wr_addr_o,
  output logic [CDW-1:0]      csr_wr_data_o,
  output logic                retire_o,
  output logic [c_chw-1:0]    retire_ch_o,
  output logic                busy_o
);

  localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;

  typedef struct packed {
    logic            regs_wen;
    logic [RAW-1:0]  rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            csr_wen;
    logic [CAW-1:0]  csr_addr;
    logic [CDW-1:0]  csr_data;
  } entry_t;

  entry_t           w_in   [NCH];
  entry_t           w_head [NCH];
  entry_t           w_sel;
  logic [NCH-1:0]   w_empty;
  logic [NCH-1:0]   w_full;
  logic [NCH-1:0]   w_push;
  logic [NCH-1:0]   w_pop;
  logic             w_gnt_valid;
  logic [c_chw-1:0] w_gnt;
  logic [c_chw-1:0] w_idx;
  logic [c_chw-1:0] r_rr;

  generate
    for (genvar k = 0; k < NCH; k++) begin : g_ch
      entry_t             r_mem [DEPTH];
      logic [c_ptr_w-1:0] r_wr;
      logic [c_ptr_w-1:0] r_rd;
      logic [c_cnt_w-1:0] r_cnt;

      assign w_in[k] = {ch_regs_wen_i[k], ch_rd_addr_i[k*RAW +: RAW],
                        ch_rd_data_i[k*XLEN +: XLEN], ch_csr_wen_i[k],
                        ch_csr_addr_i[k*CAW +: CAW], ch_csr_data_i[k*CDW +: CDW]};

      assign w_empty[k] = (r_cnt == '0);
      assign w_full[k]  = (r_cnt == c_cnt_w'(DEPTH));
      // Full channels refuse pushes even when popped this cycle: no bypass.
      assign w_push[k]  = ch_valid_i[k] & ~w_full[k];
      assign w_pop[k]   = w_gnt_valid & (w_gnt == c_chw'(k));
      assign w_head[k]  = r_mem[r_rd];

      always_ff @(posedge clk) begin
        if (w_push[k]) begin
          r_mem[r_wr] <= w_in[k];
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_wr  <= '0;
          r_rd  <= '0;
          r_cnt <= '0;
        end else begin
          if (w_push[k]) begin
            r_wr <= r_wr + 1'b1;
          end
          if (w_pop[k]) begin
            r_rd <= r_rd + 1'b1;
          end
          case ({w_push[k], w_pop[k]})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
          endcase
        end
      end
    end
  endgenerate

  assign ch_ready_o = ~w_full;
  assign busy_o     = |(~w_empty);

  // First non-empty channel at or after the priority pointer, wrapping once.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = '0;
    w_idx       = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(r_rr) + i >= NCH) begin
        w_idx = c_chw'(int'(r_rr) + i - NCH);
      end else begin
        w_idx = c_chw'(int'(r_rr) + i);
      end
      if (!w_gnt_valid && !w_empty[w_idx]) begin
        w_gnt_valid = 1'b1;
        w_gnt       = w_idx;
      end
    end
  end

  assign w_sel = w_head[w_gnt];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr          <= '0;
      regs_wen_o    <= 1'b0;
      rd_addr_o     <= '0;
      rd_data_o     <= '0;
      csr_wen_o     <= 1'b0;
      csr_wr_addr_o <= '0;
      csr_wr_data_o <= '0;
      retire_o      <= 1'b0;
      retire_ch_o   <= '0;
    end else begin
      regs_wen_o <= 1'b0;
      csr_wen_o  <= 1'b0;
      retire_o   <= 1'b0;
      if (w_gnt_valid) begin
        // x0 writes are dropped here but the entry still retires.
        regs_wen_o    <= w_sel.regs_wen & (w_sel.rd_addr != '0);
        rd_addr_o     <= w_sel.rd_addr;
        rd_data_o     <= w_sel.rd_data;
        csr_wen_o     <= w_sel.csr_wen;
        csr_wr_addr_o <= w_sel.csr_addr;
        csr_wr_data_o <= w_sel.csr_data;
        retire_o      <= 1'b1;
        retire_ch_o   <= w_gnt;
        r_rr          <= (w_gnt == c_chw'(NCH - 1)) ? '0 : w_gnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_wb_arb                                                       |
// | Purpose  : Directed scoreboard bench for wb_arb (NCH=3, DEPTH=2).          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_wb_arb;

  localparam int NCH = 3;
  localparam logic [31:0] c_marker = 32'hB0B0_0001;

  typedef struct packed {
    logic        rwen;
    logic [4:0]  rd;
    logic [31:0] rdat;
    logic        cwen;
    logic [11:0] caddr;
    logic [31:0] cdat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rstn;
  logic [2:0]     ch_valid_i;
  logic [2:0]     ch_ready_o;
  logic [2:0]     ch_regs_wen_i;
  logic [14:0]    ch_rd_addr_i;
  logic [95:0]    ch_rd_data_i;
  logic [2:0]     ch_csr_wen_i;
  logic [35:0]    ch_csr_addr_i;
  logic [95:0]    ch_csr_data_i;
  logic           regs_wen_o;
  logic [4:0]     rd_addr_o;
  logic [31:0]    rd_data_o;
  logic           csr_wen_o;
  logic [11:0]    csr_wr_addr_o;
  logic [31:0]    csr_wr_data_o;
  logic           retire_o;
  logic [1:0]     retire_ch_o;
  logic           busy_o;

  logic        vld   [NCH];
  logic        rwen  [NCH];
  logic [4:0]  rd    [NCH];
  logic [31:0] rdat  [NCH];
  logic        cwen  [NCH];
  logic [11:0] caddr [NCH];
  logic [31:0] cdat  [NCH];

  exp_t exp_q [NCH][$];
  int   tests = 0;
  int   fails = 0;
  int   ret_cnt [NCH];
  int   marker_cnt = 0;
  int   seq = 0;

  wb_arb dut (
    .clk(clk), .rstn(rstn),
    .ch_valid_i(ch_valid_i), .ch_ready_o(ch_ready_o),
    .ch_regs_wen_i(ch_regs_wen_i), .ch_rd_addr_i(ch_rd_addr_i), .ch_rd_data_i(ch_rd_data_i),
    .ch_csr_wen_i(ch_csr_wen_i), .ch_csr_addr_i(ch_csr_addr_i), .ch_csr_data_i(ch_csr_data_i),
    .regs_wen_o(regs_wen_o), .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o),
    .csr_wen_o(csr_wen_o), .csr_wr_addr_o(csr_wr_addr_o), .csr_wr_data_o(csr_wr_data_o),
    .retire_o(retire_o), .retire_ch_o(retire_ch_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always_comb begin
    ch_valid_i = '0; ch_regs_wen_i = '0; ch_rd_addr_i = '0; ch_rd_data_i = '0;
    ch_csr_wen_i = '0; ch_csr_addr_i = '0; ch_csr_data_i = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_valid_i[k]             = vld[k];
      ch_regs_wen_i[k]          = rwen[k];
      ch_rd_addr_i[k*5 +: 5]    = rd[k];
      ch_rd_data_i[k*32 +: 32]  = rdat[k];
      ch_csr_wen_i[k]           = cwen[k];
      ch_csr_addr_i[k*12 +: 12] = caddr[k];
      ch_csr_data_i[k*32 +: 32] = cdat[k];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor pops the scoreboard on each retire; recorder pushes on each handshake
  // that the next rising edge will perform (inputs and ready are stable here).
  always @(negedge clk) begin
    if (rstn && retire_o) begin
      check("retire_ch_range", 64'(retire_ch_o < 2'd3), 64'd1);
      if (retire_ch_o < 2'd3) begin
        check("sb_has_entry", 64'(exp_q[retire_ch_o].size() != 0), 64'd1);
        if (exp_q[retire_ch_o].size() != 0) begin
          exp_t e;
          e = exp_q[retire_ch_o].pop_front();
          ret_cnt[retire_ch_o]++;
          check("sb_regs_wen", 64'(regs_wen_o), 64'(e.rwen));
          check("sb_rd_addr", 64'(rd_addr_o), 64'(e.rd));
          check("sb_rd_data", 64'(rd_data_o), 64'(e.rdat));
          check("sb_csr_wen", 64'(csr_wen_o), 64'(e.cwen));
          check("sb_csr_addr", 64'(csr_wr_addr_o), 64'(e.caddr));
          check("sb_csr_data", 64'(csr_wr_data_o), 64'(e.cdat));
          if (retire_ch_o == 2'd2 && rd_data_o == c_marker) marker_cnt++;
        end
      end
    end
    if (rstn) begin
      for (int k = 0; k < NCH; k++) begin
        if (vld[k] && ch_ready_o[k]) begin
          exp_t e;
          e.rwen  = rwen[k] & (rd[k] != 5'd0);
          e.rd    = rd[k];
          e.rdat  = rdat[k];
          e.cwen  = cwen[k];
          e.caddr = caddr[k];
          e.cdat  = cdat[k];
          exp_q[k].push_back(e);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic rw, input logic [4:0] a, input logic [31:0] d,
                        input logic cw, input logic [11:0] ca, input logic [31:0] cd);
    vld[k] = 1'b1; rwen[k] = rw; rd[k] = a; rdat[k] = d;
    cwen[k] = cw; caddr[k] = ca; cdat[k] = cd;
  endtask

  task automatic fresh(input int k);
    seq++;
    set_ch(k, 1'b1, 5'(10 + (seq % 16)), 32'h5000_0000 | 32'(seq), 1'b0, 12'h0, 32'h0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((busy_o || retire_o) && n < 50) begin
      tick;
      n++;
    end
    check({tag, "_drain_timeout"}, 64'(n < 50), 64'd1);
  endtask

  initial begin
    int n;
    int base;
    logic acc [NCH];
    logic got;
    for (int k = 0; k < NCH; k++) begin
      vld[k] = 0; rwen[k] = 0; rd[k] = 0; rdat[k] = 0; cwen[k] = 0; caddr[k] = 0; cdat[k] = 0;
      ret_cnt[k] = 0; acc[k] = 0;
    end
    rstn = 1'b0;
    tick; tick;
    check("rst_retire", 64'(retire_o), 64'd0);
    check("rst_regs_wen", 64'(regs_wen_o), 64'd0);
    check("rst_csr_wen", 64'(csr_wen_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    rstn = 1'b1;
    check("rst_ready", 64'(ch_ready_o), 64'h7);

    // Round-robin from rr=0: two entries per channel, expect 0,1,2,0,1,2.
    for (int k = 0; k < NCH; k++) set_ch(k, 1'b1, 5'(1 + k), 32'h100 + 32'(k), 1'b0, 12'h0, 32'h0);
    tick;
    for (int k = 0; k < NCH; k++) set_ch(k, 1'b1, 5'(4 + k), 32'h200 + 32'(k), 1'b0, 12'h0, 32'h0);
    tick;
    for (int k = 0; k < NCH; k++) vld[k] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) tick;
      check("rr_retire", 64'(retire_o), 64'd1);
      check("rr_order", 64'(retire_ch_o), 64'(i % 3));
    end
    tick;
    check("rr_idle", 64'(retire_o), 64'd0);
    drain("rr");

    // Single write with two-edge latency.
    set_ch(1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 12'h0, 32'h0);
    tick;
    vld[1] = 1'b0;
    check("single_latency", 64'(retire_o), 64'd0);
    tick;
    check("single_wen", 64'(regs_wen_o), 64'd1);
    check("single_addr", 64'(rd_addr_o), 64'd5);
    check("single_data", 64'(rd_data_o), 64'hDEAD_BEEF);
    check("single_ch", 64'(retire_ch_o), 64'd1);
    tick;
    check("single_wen_clr", 64'(regs_wen_o), 64'd0);

    // x0 suppression with a CSR write in the same entry.
    set_ch(0, 1'b1, 5'd0, 32'h80, 1'b1, 12'h305, 32'h80);
    tick;
    vld[0] = 1'b0;
    tick;
    check("x0_regs_wen", 64'(regs_wen_o), 64'd0);
    check("x0_csr_wen", 64'(csr_wen_o), 64'd1);
    check("x0_csr_addr", 64'(csr_wr_addr_o), 64'h305);
    check("x0_csr_data", 64'(csr_wr_data_o), 64'h80);
    check("x0_retire", 64'(retire_o), 64'd1);

    // Entry with no enables still retires.
    set_ch(2, 1'b0, 5'd7, 32'h77, 1'b0, 12'h0, 32'h0);
    tick;
    vld[2] = 1'b0;
    tick;
    check("noen_retire", 64'(retire_o), 64'd1);
    check("noen_wens", 64'({regs_wen_o, csr_wen_o}), 64'd0);
    check("noen_ch", 64'(retire_ch_o), 64'd2);
    drain("misc");

    // Pointer wrap: ten back-to-back entries through ch0 alone.
    base = ret_cnt[0];
    for (int i = 0; i < 10; i++) begin
      set_ch(0, 1'b1, 5'(i + 1), 32'h1000 + 32'(i), 1'b0, 12'h0, 32'h0);
      check("wrap_ready", 64'(ch_ready_o[0]), 64'd1);
      tick;
      if (i != 0) begin
        check("wrap_retire", 64'(retire_o), 64'd1);
        check("wrap_data", 64'(rd_data_o), 64'h1000 + 64'(i - 1));
      end
    end
    vld[0] = 1'b0;
    tick;
    check("wrap_last", 64'(rd_data_o), 64'h1009);
    drain("wrap");
    check("wrap_count", 64'(ret_cnt[0] - base), 64'd10);

    // Back-pressure: contend on all channels until ch2 fills, then hold a marker.
    for (int k = 0; k < NCH; k++) fresh(k);
    n = 0;
    while (ch_ready_o[2] && n < 40) begin
      for (int k = 0; k < NCH; k++) acc[k] = vld[k] & ch_ready_o[k];
      tick;
      for (int k = 0; k < NCH; k++) if (acc[k]) fresh(k);
      n++;
    end
    check("bp_ch2_full", 64'(ch_ready_o[2]), 64'd0);
    set_ch(2, 1'b1, 5'd9, c_marker, 1'b0, 12'h0, 32'h0);
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      for (int k = 0; k < NCH; k++) acc[k] = vld[k] & ch_ready_o[k];
      tick;
      for (int k = 0; k < 2; k++) if (acc[k]) fresh(k);
      got = acc[2];
      n++;
    end
    vld[2] = 1'b0;
    check("bp_accepted", 64'(got), 64'd1);
    vld[0] = 1'b0; vld[1] = 1'b0;
    drain("bp");
    check("bp_marker_once", 64'(marker_cnt), 64'd1);

    // Asynchronous reset with ch0 full: in-flight entries are discarded.
    for (int k = 0; k < NCH; k++) fresh(k);
    n = 0;
    while (ch_ready_o[0] && n < 40) begin
      for (int k = 0; k < NCH; k++) acc[k] = vld[k] & ch_ready_o[k];
      tick;
      for (int k = 0; k < NCH; k++) if (acc[k]) fresh(k);
      n++;
    end
    for (int k = 0; k < NCH; k++) vld[k] = 1'b0;
    check("ar_ch0_full", 64'(ch_ready_o[0]), 64'd0);
    check("ar_busy_pre", 64'(busy_o), 64'd1);
    rstn = 1'b0;
    for (int k = 0; k < NCH; k++) exp_q[k].delete();
    #1;
    check("ar_retire", 64'(retire_o), 64'd0);
    check("ar_wens", 64'({regs_wen_o, csr_wen_o}), 64'd0);
    check("ar_addr_data", 64'({rd_addr_o, rd_data_o}), 64'd0);
    check("ar_csr", 64'({csr_wr_addr_o, csr_wr_data_o}), 64'd0);
    check("ar_ch", 64'(retire_ch_o), 64'd0);
    check("ar_busy", 64'(busy_o), 64'd0);
    tick;
    rstn = 1'b1;
    check("ar_ready", 64'(ch_ready_o), 64'h7);
    base = ret_cnt[0] + ret_cnt[1] + ret_cnt[2];
    repeat (5) tick;
    check("ar_no_stale", 64'(ret_cnt[0] + ret_cnt[1] + ret_cnt[2] - base), 64'd0);

    for (int k = 0; k < NCH; k++) check("sb_empty_end", 64'(exp_q[k].size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arb.md
# wb_arb

Parametrised write-back arbiter for the pipeline's final stage. It accepts GPR and CSR write-back results from `NCH` independent producers (for example the ALU pipe, the load unit and the mul/div unit), buffers each in a per-channel FIFO and drains them through a fair round-robin arbiter. Each cycle it drives at most one registered write to the register file and one to the CSR file. It replaces the single-channel pass-through write-back stage and adds buffering, back-pressure, arbitration and x0 filtering.

## Interface
Parameters:
- `NCH`, 3: number of producer channels, 2..8.
- `DEPTH`, 2: FIFO entries per channel; power of two, at least 2.
- `XLEN`, 32: GPR data width.
- `RAW`, 5: GPR address width.
- `CAW`, 12: CSR address width.
- `CDW`, 32: CSR data width.

Ports (channel k occupies slice `[k*W +: W]` of each flattened bus):
- `clk` in 1: clock; all state updates on its rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `ch_valid_i` in NCH: producer k offers an entry.
- `ch_ready_o` out NCH: channel k can accept; equals !full[k], from registered state only.
- `ch_regs_wen_i` in NCH: GPR write request.
- `ch_rd_addr_i` in NCH*RAW: GPR destination.
- `ch_rd_data_i` in NCH*XLEN: GPR data.
- `ch_csr_wen_i` in NCH: CSR write request.
- `ch_csr_addr_i` in NCH*CAW: CSR address.
- `ch_csr_data_i` in NCH*CDW: CSR data.
- `regs_wen_o` out 1: register-file write enable.
- `rd_addr_o` out RAW: register-file write address.
- `rd_data_o` out XLEN: register-file write data.
- `csr_wen_o` out 1: CSR write enable.
- `csr_wr_addr_o` out CAW: CSR write address.
- `csr_wr_data_o` out CDW: CSR write data.
- `retire_o` out 1: one entry left the arbiter this cycle.
- `retire_ch_o` out $clog2(NCH): channel of the retired entry (0 if NCH=1 clamp width to 1).
- `busy_o` out 1: some FIFO is non-empty.

## Operation
- **Per-channel FIFO:** circular buffer with rd/wr pointers of $clog2(DEPTH) bits plus a count of $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- **Push:** occurs when `ch_valid_i[k] & ch_ready_o[k]`. The entry stores all six fields. Valid while not ready is held by the producer, which must not change the payload.
- **Arbitration:** combinational round-robin over `!empty[k]`. The search starts at the priority pointer `rr`, which resets to 0. After a grant to channel g, `rr` becomes (g+1) mod NCH. With no requester, `rr` holds. At most one pop per cycle.
- **Simultaneous push and pop** on the same channel: both take effect and the count is unchanged. On a full channel no push occurs (ready=0), even if a pop happens that cycle. There is no same-cycle bypass.
- **Output register:** loaded on a pop.
  - `regs_wen_o` = entry.regs_wen & (rd != 0). A write to x0 is suppressed, but the entry is still consumed and retired.
  - `csr_wen_o` = entry.csr_wen.
  - Both enables can be set in the same cycle (for example, CSRRW).
  - An entry with neither enable set still retires, giving `retire_o`=1 with both wens 0.
- **No pop:** `regs_wen_o`, `csr_wen_o` and `retire_o` are 0. The address and data outputs hold their last value.
- **`busy_o`:** OR of the non-empty flags, from registered state.

## Timing
- **Reset** (rstn=0, asynchronous): all FIFOs are emptied, `rr`=0, and every output is 0. `ch_ready_o` is all ones once reset is removed, since the FIFOs are empty. Entries in flight during reset are discarded.
- **Latency:** an entry pushed at edge N is eligible for the arbiter in the cycle after edge N. If granted, it pops at edge N+1, so the outputs are valid in the cycle after edge N+1.
- **Throughput:** one retire per cycle overall. An uncontested channel sustains one entry per cycle with DEPTH>=2.
- **Worst-case wait:** an entry at the head of its FIFO waits at most NCH-1 grants to other channels.
- **Order:** strictly FIFO within a channel. There is no ordering guarantee across channels; producers resolve hazards upstream.

## Test plan
- **Reset:** assert rstn=0 mid-traffic with 2 entries in ch0. Response: all outputs 0 immediately, FIFOs empty, `ch_ready_o`=3'b111 after release, the stale entries never retire.
- **Single write:** push ch1 {wen=1, rd=5, data=0xDEADBEEF} at edge N. Response: after edge N+1, `regs_wen_o`=1, `rd_addr_o`=5, `rd_data_o`=0xDEADBEEF, `retire_ch_o`=1; `regs_wen_o`=0 in the following cycle.
- **Round-robin:** all three channels each hold 2 entries. Response: grant order 0,1,2,0,1,2, with 6 consecutive retire cycles.
- **Back-pressure:** fill ch2 with 2 entries while ch0 and ch1 keep winning. Response: `ch_ready_o[2]`=0; a held valid with constant payload is accepted exactly once after ch2 pops.
- **x0 and CSR:** push {regs_wen=1, rd=0, csr_wen=1, csr_addr=0x305, data=0x80}. Response: `regs_wen_o`=0, `csr_wen_o`=1, `csr_wr_addr_o`=0x305, `retire_o`=1.
- **Pointer wrap:** stream 10 entries with incrementing data through ch0 alone at one per cycle. Response: outputs are 10 consecutive retires in push order, with no drop and no duplicate.
